// File: rtl/rf_cmd_sequencer_if.sv
// Command/response handshake bundle for rf_cmd_sequencer.
//   cmd_*  : command channel, valid/ready, initiator -> sequencer
//   rsp_*  : response channel, valid/ready, sequencer -> initiator
// Modports: master = command initiator, slave = sequencer.
interface rf_cmd_sequencer_if #(
   parameter int unsigned N         = 8,
   parameter int unsigned ADDR_BITS = 2
) ();
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [1:0]           cmd_op;
   logic [ADDR_BITS-1:0] cmd_addr_a;
   logic [ADDR_BITS-1:0] cmd_addr_b;
   logic [N-1:0]         cmd_data;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [N-1:0]         rsp_data_a;
   logic [N-1:0]         rsp_data_b;
   logic                 rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err
   );
endinterface

// File: rtl/rf_cmd_sequencer.sv
// Command-driven initiator for the lab register file. Accepts READ/WRITE/COPY/SWAP
// commands, owns every RF control signal and returns read data as a response.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       cmd_* command channel / rsp_* response channel
//   rf_write_en/addr  RF write strobe and address
//   rf_sel_source     RF write source select (00 = input A, 01 = input B)
//   rf_data_a/b       RF inputs A/B
//   rf_read_addr_a/b  RF read addresses
//   rf_sel_dest_a/b   RF destination selects, tied to 0 (outputs 1A/1B)
//   rf_q_a/b          RF combinational read data
// Build option: define RF_WRITE_PROTECT_EN to make register 0 read-only and
// report suppressed writes through rsp_err.
module rf_cmd_sequencer #(
   parameter int unsigned N         = 8,
   parameter int unsigned ADDR_BITS = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rf_cmd_sequencer_if.slave    bus,
   output logic                 rf_write_en,
   output logic [ADDR_BITS-1:0] rf_write_addr,
   output logic [1:0]           rf_sel_source,
   output logic [N-1:0]         rf_data_a,
   output logic [N-1:0]         rf_data_b,
   output logic [ADDR_BITS-1:0] rf_read_addr_a,
   output logic [ADDR_BITS-1:0] rf_read_addr_b,
   output logic                 rf_sel_dest_a,
   output logic                 rf_sel_dest_b,
   input  logic [N-1:0]         rf_q_a,
   input  logic [N-1:0]         rf_q_b
);

`ifdef RF_WRITE_PROTECT_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_COPY  = 2'b10;
   localparam logic [1:0] OP_SWAP  = 2'b11;

   typedef enum logic [2:0] {IDLE, RD, WR, SW2, RESP} state_t;

   state_t               state_q, state_d;
   logic [1:0]           op_q, op_d;
   logic [ADDR_BITS-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
   logic [N-1:0]         data_q, data_d;
   logic [N-1:0]         hold_a_q, hold_a_d, hold_b_q, hold_b_d;
   logic                 err_q, err_d;
   logic [ADDR_BITS-1:0] wr_tgt;

   logic                 cmd_ready_q, cmd_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [N-1:0]         rsp_data_a_q, rsp_data_a_d, rsp_data_b_q, rsp_data_b_d;
   logic                 rsp_err_q, rsp_err_d;
   logic                 rf_write_en_q, rf_write_en_d;
   logic [ADDR_BITS-1:0] rf_write_addr_q, rf_write_addr_d;
   logic [1:0]           rf_sel_source_q, rf_sel_source_d;
   logic [N-1:0]         rf_data_a_q, rf_data_a_d, rf_data_b_q, rf_data_b_d;
   logic [ADDR_BITS-1:0] rf_read_addr_a_q, rf_read_addr_a_d;
   logic [ADDR_BITS-1:0] rf_read_addr_b_q, rf_read_addr_b_d;

   // Next state, command latch and holding registers; then every registered
   // output is derived from the next state so it lines up with that state.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_a_d = addr_a_q;
      addr_b_d = addr_b_q;
      data_d   = data_q;
      hold_a_d = hold_a_q;
      hold_b_d = hold_b_q;
      err_d    = err_q;
      wr_tgt   = '0;

      cmd_ready_d      = 1'b0;
      rsp_valid_d      = 1'b0;
      rsp_data_a_d     = '0;
      rsp_data_b_d     = '0;
      rsp_err_d        = 1'b0;
      rf_write_en_d    = 1'b0;
      rf_write_addr_d  = '0;
      rf_sel_source_d  = 2'b00;
      rf_data_a_d      = '0;
      rf_data_b_d      = '0;
      rf_read_addr_a_d = '0;
      rf_read_addr_b_d = '0;

      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               op_d     = bus.cmd_op;
               addr_a_d = bus.cmd_addr_a;
               addr_b_d = bus.cmd_addr_b;
               data_d   = bus.cmd_data;
               err_d    = 1'b0;
               state_d  = (bus.cmd_op == OP_WRITE) ? WR : RD;
            end
         end
         RD: begin
            hold_a_d = rf_q_a;
            hold_b_d = rf_q_b;
            state_d  = (op_q == OP_READ) ? RESP : WR;
         end
         WR:   state_d = (op_q == OP_SWAP) ? SW2 : RESP;
         SW2:  state_d = RESP;
         RESP: if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      case (state_d)
         IDLE: cmd_ready_d = 1'b1;
         RD: begin
            rf_read_addr_a_d = addr_a_d;
            rf_read_addr_b_d = addr_b_d;
         end
         WR: begin
            // WRITE targets a; COPY and the first SWAP write target b.
            wr_tgt          = (op_d == OP_WRITE) ? addr_a_d : addr_b_d;
            rf_write_addr_d = wr_tgt;
            rf_data_a_d     = (op_d == OP_WRITE) ? data_d : hold_a_d;
            if (WP && wr_tgt == '0) err_d = 1'b1;
            else                    rf_write_en_d = 1'b1;
         end
         SW2: begin
            rf_write_addr_d = addr_a_d;
            rf_sel_source_d = 2'b01;
            rf_data_b_d     = hold_b_d;
            if (WP && addr_a_d == '0) err_d = 1'b1;
            else                      rf_write_en_d = 1'b1;
         end
         RESP: begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_d;
            case (op_d)
               OP_WRITE: rsp_data_a_d = data_d;
               OP_COPY:  rsp_data_a_d = hold_a_d;
               default: begin
                  rsp_data_a_d = hold_a_d;
                  rsp_data_b_d = hold_b_d;
               end
            endcase
         end
         default: ;
      endcase
   end

   // State, command latch and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         op_q             <= OP_READ;
         addr_a_q         <= '0;
         addr_b_q         <= '0;
         data_q           <= '0;
         hold_a_q         <= '0;
         hold_b_q         <= '0;
         err_q            <= 1'b0;
         cmd_ready_q      <= 1'b1;
         rsp_valid_q      <= 1'b0;
         rsp_data_a_q     <= '0;
         rsp_data_b_q     <= '0;
         rsp_err_q        <= 1'b0;
         rf_write_en_q    <= 1'b0;
         rf_write_addr_q  <= '0;
         rf_sel_source_q  <= 2'b00;
         rf_data_a_q      <= '0;
         rf_data_b_q      <= '0;
         rf_read_addr_a_q <= '0;
         rf_read_addr_b_q <= '0;
      end else begin
         state_q          <= state_d;
         op_q             <= op_d;
         addr_a_q         <= addr_a_d;
         addr_b_q         <= addr_b_d;
         data_q           <= data_d;
         hold_a_q         <= hold_a_d;
         hold_b_q         <= hold_b_d;
         err_q            <= err_d;
         cmd_ready_q      <= cmd_ready_d;
         rsp_valid_q      <= rsp_valid_d;
         rsp_data_a_q     <= rsp_data_a_d;
         rsp_data_b_q     <= rsp_data_b_d;
         rsp_err_q        <= rsp_err_d;
         rf_write_en_q    <= rf_write_en_d;
         rf_write_addr_q  <= rf_write_addr_d;
         rf_sel_source_q  <= rf_sel_source_d;
         rf_data_a_q      <= rf_data_a_d;
         rf_data_b_q      <= rf_data_b_d;
         rf_read_addr_a_q <= rf_read_addr_a_d;
         rf_read_addr_b_q <= rf_read_addr_b_d;
      end
   end

   assign bus.cmd_ready  = cmd_ready_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_data_a = rsp_data_a_q;
   assign bus.rsp_data_b = rsp_data_b_q;
   assign bus.rsp_err    = rsp_err_q;

   assign rf_write_en    = rf_write_en_q;
   assign rf_write_addr  = rf_write_addr_q;
   assign rf_sel_source  = rf_sel_source_q;
   assign rf_data_a      = rf_data_a_q;
   assign rf_data_b      = rf_data_b_q;
   assign rf_read_addr_a = rf_read_addr_a_q;
   assign rf_read_addr_b = rf_read_addr_b_q;

   // Only destination outputs 1A/1B are used.
   assign rf_sel_dest_a  = 1'b0;
   assign rf_sel_dest_b  = 1'b0;

endmodule

// File: tb/tb_rf_cmd_sequencer.sv
// Directed bench for rf_cmd_sequencer with a behavioural 4x8 register file.
module tb_rf_cmd_sequencer;
   localparam int unsigned N  = 8;
   localparam int unsigned AB = 2;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_COPY  = 2'b10;
   localparam logic [1:0] OP_SWAP  = 2'b11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic          rf_write_en;
   logic [AB-1:0] rf_write_addr;
   logic [1:0]    rf_sel_source;
   logic [N-1:0]  rf_data_a, rf_data_b;
   logic [AB-1:0] rf_read_addr_a, rf_read_addr_b;
   logic          rf_sel_dest_a, rf_sel_dest_b;
   logic [N-1:0]  rf_q_a, rf_q_b;

   // RF reset image: reg1 = 0xFF, all others 0.
   logic [N-1:0] mem [4] = '{8'h00, 8'hFF, 8'h00, 8'h00};
   int wr_cnt = 0;

   int n_cmp = 0;
   int n_err = 0;

   rf_cmd_sequencer_if #(.N(N), .ADDR_BITS(AB)) bus ();

   rf_cmd_sequencer #(.N(N), .ADDR_BITS(AB)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .rf_write_en    (rf_write_en),
      .rf_write_addr  (rf_write_addr),
      .rf_sel_source  (rf_sel_source),
      .rf_data_a      (rf_data_a),
      .rf_data_b      (rf_data_b),
      .rf_read_addr_a (rf_read_addr_a),
      .rf_read_addr_b (rf_read_addr_b),
      .rf_sel_dest_a  (rf_sel_dest_a),
      .rf_sel_dest_b  (rf_sel_dest_b),
      .rf_q_a         (rf_q_a),
      .rf_q_b         (rf_q_b)
   );

   always #5 clk = ~clk;

   // Behavioural RF: clocked write from input A or B, combinational reads.
   always @(posedge clk) begin
      if (rf_write_en) begin
         mem[rf_write_addr] <= (rf_sel_source == 2'b01) ? rf_data_b : rf_data_a;
         wr_cnt <= wr_cnt + 1;
      end
   end

   assign rf_q_a = mem[rf_read_addr_a];
   assign rf_q_b = mem[rf_read_addr_b];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one command, hold rsp_ready low for 'stall' cycles, then handshake.
   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [1:0] a,
                          input logic [1:0] b, input logic [7:0] d, input int stall,
                          input logic [7:0] ea, input logic [7:0] eb, input logic ee,
                          input int elat, input int ewc);
      int guard;
      int lat;
      int wc0;
      @(negedge clk);
      bus.cmd_valid  = 1'b1;
      bus.cmd_op     = op;
      bus.cmd_addr_a = a;
      bus.cmd_addr_b = b;
      bus.cmd_data   = d;
      guard = 0;
      while (!bus.cmd_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) chk({tag, "_accept_timeout"}, 32'd1, 32'd0);
      wc0 = wr_cnt;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(elat));
      chk({tag, "_data_a"}, 32'(bus.rsp_data_a), 32'(ea));
      chk({tag, "_data_b"}, 32'(bus.rsp_data_b), 32'(eb));
      chk({tag, "_err"}, 32'(bus.rsp_err), 32'(ee));
      chk({tag, "_busy"}, 32'(bus.cmd_ready), 32'd0);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         chk({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
         chk({tag, "_hold_data_a"}, 32'(bus.rsp_data_a), 32'(ea));
         chk({tag, "_hold_busy"}, 32'(bus.cmd_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      chk({tag, "_rsp_cleared"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_rsp_data_cleared"}, 32'(bus.rsp_data_a), 32'd0);
      chk({tag, "_ready_again"}, 32'(bus.cmd_ready), 32'd1);
      chk({tag, "_writes"}, 32'(wr_cnt - wc0), 32'(ewc));
   endtask

   // Watch the single WRITE transaction: record the write strobe fields.
   logic [AB-1:0] last_waddr;
   logic [1:0]    last_wsrc;
   logic [N-1:0]  last_wdata;
   always @(posedge clk) begin
      if (rf_write_en) begin
         last_waddr <= rf_write_addr;
         last_wsrc  <= rf_sel_source;
         last_wdata <= (rf_sel_source == 2'b01) ? rf_data_b : rf_data_a;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = 2'b00;
      bus.cmd_addr_a = '0;
      bus.cmd_addr_b = '0;
      bus.cmd_data   = '0;
      bus.rsp_ready  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_write_en", 32'(rf_write_en), 32'd0);
      chk("reset_read_addr_a", 32'(rf_read_addr_a), 32'd0);
      chk("reset_sel_dest", 32'({rf_sel_dest_a, rf_sel_dest_b}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_cmd("read_1_0", OP_READ, 2'd1, 2'd0, 8'h00, 0, 8'hFF, 8'h00, 1'b0, 2, 0);

      run_cmd("write_2", OP_WRITE, 2'd2, 2'd0, 8'h5A, 0, 8'h5A, 8'h00, 1'b0, 2, 1);
      chk("write_2_addr", 32'(last_waddr), 32'd2);
      chk("write_2_src", 32'(last_wsrc), 32'd0);
      chk("write_2_value", 32'(last_wdata), 32'h5A);

      run_cmd("read_2_3", OP_READ, 2'd2, 2'd3, 8'h00, 0, 8'h5A, 8'h00, 1'b0, 2, 0);
      run_cmd("write_3", OP_WRITE, 2'd3, 2'd0, 8'h3C, 0, 8'h3C, 8'h00, 1'b0, 2, 1);
      run_cmd("swap_2_3", OP_SWAP, 2'd2, 2'd3, 8'h00, 0, 8'h5A, 8'h3C, 1'b0, 4, 2);
      run_cmd("read_swapped", OP_READ, 2'd2, 2'd3, 8'h00, 0, 8'h3C, 8'h5A, 1'b0, 2, 0);

      run_cmd("copy_1_3", OP_COPY, 2'd1, 2'd3, 8'h00, 5, 8'hFF, 8'h00, 1'b0, 3, 1);
      chk("copy_reg3", 32'(mem[3]), 32'hFF);

      run_cmd("copy_same", OP_COPY, 2'd2, 2'd2, 8'h00, 0, 8'h3C, 8'h00, 1'b0, 3, 1);
      run_cmd("swap_same", OP_SWAP, 2'd1, 2'd1, 8'h00, 0, 8'hFF, 8'hFF, 1'b0, 4, 2);
      chk("swap_same_reg1", 32'(mem[1]), 32'hFF);

      // SWAP 2<->3 interrupted in SW2: reg3 already holds old reg2, reg2 untouched.
      @(negedge clk);
      bus.cmd_valid  = 1'b1;
      bus.cmd_op     = OP_SWAP;
      bus.cmd_addr_a = 2'd2;
      bus.cmd_addr_b = 2'd3;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("sw2_write_en", 32'(rf_write_en), 32'd1);
      chk("sw2_addr", 32'(rf_write_addr), 32'd2);
      chk("sw2_src", 32'(rf_sel_source), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_write_en", 32'(rf_write_en), 32'd0);
      chk("abort_write_addr", 32'(rf_write_addr), 32'd0);
      chk("abort_sel_source", 32'(rf_sel_source), 32'd0);
      chk("abort_data_b", 32'(rf_data_b), 32'd0);
      chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_reg2", 32'(mem[2]), 32'h3C);
      chk("abort_reg3", 32'(mem[3]), 32'h3C);
      run_cmd("read_after_abort", OP_READ, 2'd2, 2'd3, 8'h00, 0, 8'h3C, 8'h3C, 1'b0, 2, 0);

`ifdef RF_WRITE_PROTECT_EN
      run_cmd("write_0", OP_WRITE, 2'd0, 2'd0, 8'h77, 0, 8'h77, 8'h00, 1'b1, 2, 0);
      run_cmd("read_0", OP_READ, 2'd0, 2'd1, 8'h00, 0, 8'h00, 8'hFF, 1'b0, 2, 0);
      run_cmd("swap_0_2", OP_SWAP, 2'd0, 2'd2, 8'h00, 0, 8'h00, 8'h3C, 1'b1, 4, 1);
      chk("swap_0_2_reg0", 32'(mem[0]), 32'h00);
      chk("swap_0_2_reg2", 32'(mem[2]), 32'h00);
`else
      run_cmd("write_0", OP_WRITE, 2'd0, 2'd0, 8'h77, 0, 8'h77, 8'h00, 1'b0, 2, 1);
      run_cmd("read_0", OP_READ, 2'd0, 2'd1, 8'h00, 0, 8'h77, 8'hFF, 1'b0, 2, 0);
      run_cmd("swap_0_2", OP_SWAP, 2'd0, 2'd2, 8'h00, 0, 8'h77, 8'h3C, 1'b0, 4, 2);
      chk("swap_0_2_reg0", 32'(mem[0]), 32'h3C);
      chk("swap_0_2_reg2", 32'(mem[2]), 32'h77);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
